// File: rtl/piso_pkg.sv
// Shared definitions for the 16-bit parallel-to-serial converter.
package piso_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2
  } state_e;

endpackage

// File: rtl/mux16x1.sv
// 16:1 bit multiplexer: picks one bit of the word by select.
module mux16x1
  import piso_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic              bit_o
);

  // Pure combinational bit select.
  always_comb begin
    bit_o = data_i[sel_i];
  end

endmodule

// File: rtl/piso16_serializer.sv
// Parallel-to-serial converter: accepts a 16-bit word over valid/ready, then
// steps a 4-bit mux select across it, emitting one bit per clock.
module piso16_serializer
  import piso_pkg::*;
#(
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic [SEL_W-1:0]  sel_out,
  output logic              frame_start,
  output logic              done
);

  // Value loaded into the gap counter on leaving SHIFT; the GAP state lasts
  // gap_load+1 cycles, i.e. exactly GAP_CYCLES.
  localparam logic [3:0] GapLoad = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam bit         BackToBack = (GAP_CYCLES == 0);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          gap_q, gap_d;
  logic [WORD_W-1:0]   word_q, word_d;

  logic                last_bit;
  logic                accept;
  logic [SEL_W-1:0]    sel;
  logic                raw_bit;

  assign last_bit = (state_q == StShift) && (cnt_q == 4'd15);
  // in_ready is forced low while rst is high, so a word offered during
  // reset is never accepted.
  assign in_ready = !rst && ((state_q == StIdle) || (BackToBack && last_bit));
  assign accept   = in_valid && in_ready;

  // Next-state logic for the FSM, bit counter, gap counter and held word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          cnt_d   = '0;
          word_d  = in_data;
        end
      end
      StShift: begin
        // At cnt==15 this wraps to 0, which is the start of a back-to-back word.
        cnt_d = cnt_q + 4'd1;
        if (last_bit) begin
          if (BackToBack) begin
            if (accept) begin
              state_d = StShift;
              word_d  = in_data;
            end else begin
              state_d = StIdle;
            end
          end else begin
            state_d = StGap;
            gap_d   = GapLoad;
          end
        end
      end
      StGap: begin
        if (gap_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
    end
  end

  assign sel = MSB_FIRST ? (4'd15 - cnt_q) : cnt_q;

  mux16x1 u_mux (
    .data_i (word_q),
    .sel_i  (sel),
    .bit_o  (raw_bit)
  );

  // Output decode; everything is gated by ser_valid, which itself is low in reset.
  always_comb begin
    ser_valid   = !rst && (state_q == StShift);
    ser_out     = raw_bit & ser_valid;
    sel_out     = ser_valid ? sel : '0;
    frame_start = ser_valid && (cnt_q == 4'd0);
    done        = ser_valid && (cnt_q == 4'd15);
  end

endmodule

// File: tb/tb_piso16_serializer.sv
// Scoreboard bench: dut 0 is LSB-first back-to-back, dut 1 is MSB-first with
// a 3-cycle gap. Stimulus pushes expected bits; monitors pop on ser_valid.
module tb_piso16_serializer;

  logic        clk = 1'b0;
  logic        rst         [2];
  logic [15:0] in_data     [2];
  logic        in_valid    [2];
  logic        in_ready    [2];
  logic        ser_out     [2];
  logic        ser_valid   [2];
  logic [3:0]  sel_out     [2];
  logic        frame_start [2];
  logic        done        [2];

  typedef struct packed {
    logic       b;
    logic [3:0] sel;
    logic       fs;
    logic       dn;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  piso16_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut0 (
    .clk         (clk),
    .rst         (rst[0]),
    .in_data     (in_data[0]),
    .in_valid    (in_valid[0]),
    .in_ready    (in_ready[0]),
    .ser_out     (ser_out[0]),
    .ser_valid   (ser_valid[0]),
    .sel_out     (sel_out[0]),
    .frame_start (frame_start[0]),
    .done        (done[0])
  );

  piso16_serializer #(.MSB_FIRST(1'b1), .GAP_CYCLES(3)) dut1 (
    .clk         (clk),
    .rst         (rst[1]),
    .in_data     (in_data[1]),
    .in_valid    (in_valid[1]),
    .in_ready    (in_ready[1]),
    .ser_out     (ser_out[1]),
    .ser_valid   (ser_valid[1]),
    .sel_out     (sel_out[1]),
    .frame_start (frame_start[1]),
    .done        (done[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected emission order for one word.
  task automatic push_word(input int d, input logic [15:0] w, input bit msb);
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.sel = msb ? 4'(15 - i) : 4'(i);
      e.b   = w[e.sel];
      e.fs  = (i == 0);
      e.dn  = (i == 15);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (ser_valid[d]) begin
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bit dut%0d: got ser_valid=1, expected no frame at %0t",
                 d, $time);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("ser_out_d%0d", d), 32'(ser_out[d]), 32'(e.b));
        chk($sformatf("sel_out_d%0d", d), 32'(sel_out[d]), 32'(e.sel));
        chk($sformatf("frame_start_d%0d", d), 32'(frame_start[d]), 32'(e.fs));
        chk($sformatf("done_d%0d", d), 32'(done[d]), 32'(e.dn));
      end
    end else begin
      chk($sformatf("idle_outputs_d%0d", d),
          32'({ser_out[d], frame_start[d], done[d], sel_out[d]}), 32'(0));
    end
  endtask

  // Monitors sample mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Offer a word, wait (bounded) for in_ready, then return just after the accept edge.
  task automatic send(input int d, input logic [15:0] w, input bit msb);
    bit found;
    found       = 1'b0;
    in_data[d]  = w;
    in_valid[d] = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (in_ready[d]) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got in_ready=0 for 40 cycles, expected 1", d);
    end else begin
      push_word(d, w, msb);
    end
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int  vcnt;
    bit  sent2;

    rst[0] = 1'b1;  rst[1] = 1'b1;
    in_valid[0] = 1'b1; in_valid[1] = 1'b0;
    in_data[0] = 16'hBEEF; in_data[1] = 16'h0000;

    // 1. Reset held 3 cycles with in_valid high: nothing accepted, outputs 0.
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready[0]), 32'(0));
      chk("rst_ser_valid", 32'(ser_valid[0]), 32'(0));
    end
    @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0; in_valid[0] = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_d0", 32'(in_ready[0]), 32'(1));
    chk("post_rst_ready_d1", 32'(in_ready[1]), 32'(1));
    @(posedge clk);
    #1;

    // 2. LSB-first word; in_ready only rises on the last bit.
    send(0, 16'h33ff, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("t2_in_ready", 32'(in_ready[0]), 32'(i == 16));
    end
    @(posedge clk);
    #1 chk("t2_drained", 32'(q0.size()), 32'(0));

    // 3+5. MSB-first word on the gapped instance, then 3 idle gap cycles.
    send(1, 16'h8001, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("t3_in_ready", 32'(in_ready[1]), 32'(0));
    end
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk("t5_gap_ready", 32'(in_ready[1]), 32'(0));
      chk("t5_gap_valid", 32'(ser_valid[1]), 32'(0));
    end
    @(negedge clk);
    chk("t5_ready_after_gap", 32'(in_ready[1]), 32'(1));
    @(posedge clk);
    #1 chk("t3_drained", 32'(q1.size()), 32'(0));

    // 4. Back-to-back: second word taken on the last bit of the first.
    send(0, 16'hAAAA, 1'b0);
    in_data[0]  = 16'h5555;
    in_valid[0] = 1'b1;
    vcnt  = 0;
    sent2 = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (ser_valid[0]) vcnt++;
      if (!sent2 && in_ready[0]) begin
        chk("t4_ready_cycle", 32'(i), 32'(16));
        push_word(0, 16'h5555, 1'b0);
        sent2 = 1'b1;
      end
      @(posedge clk);
      #1 if (sent2) in_valid[0] = 1'b0;
    end
    in_valid[0] = 1'b0;
    chk("t4_valid_count", 32'(vcnt), 32'(32));
    @(negedge clk);
    chk("t4_idle_after", 32'(ser_valid[0]), 32'(0));
    @(posedge clk);
    #1 chk("t4_drained", 32'(q0.size()), 32'(0));

    // 6. Abort with reset during bit 7, then a clean word.
    send(0, 16'hFFFF, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst[0] = 1'b1;
    q0.delete();
    @(negedge clk);
    chk("t6_rst_valid", 32'(ser_valid[0]), 32'(0));
    chk("t6_rst_done", 32'(done[0]), 32'(0));
    chk("t6_rst_ready", 32'(in_ready[0]), 32'(0));
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    chk("t6_idle_ready", 32'(in_ready[0]), 32'(1));
    chk("t6_idle_valid", 32'(ser_valid[0]), 32'(0));
    @(posedge clk);
    #1;
    send(0, 16'h0001, 1'b0);
    repeat (17) @(negedge clk);
    @(posedge clk);
    #1;
    chk("t6_drained", 32'(q0.size()), 32'(0));
    chk("final_drained_d1", 32'(q1.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
